serial_add_ctrl: RTL and testbench

Byte-serial add/subtract sequencer. One 8-bit ripple adder slice (`nbitAdder` with `bits=8`) processes a `WORDS`-byte operand pair, least-significant byte first, one byte per clock. The controller captures the operands, chains the carry through a register, assembles the result and reports completion. It is the wide-arithmetic front end for datapaths that cannot afford a full-width combinational adder.

---
 rtl/serial_add_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - byte-serial add/subtract sequencer around one 8-bit ripple slice
// Operands are consumed LSB byte first; the carry is chained through carry_q between cycles.

module nbitAdder #(
   parameter int bits = 8
) (
   input  logic [bits-1:0] x_i,
   input  logic [bits-1:0] y_i,
   input  logic            ci_i,
   output logic [bits-1:0] s_o,
   output logic            co_o
);

   logic ripple;

   always_comb begin
      ripple = ci_i;
      s_o    = '0;
      for (int i = 0; i < bits; i++) begin
         s_o[i] = x_i[i] ^ y_i[i] ^ ripple;
         ripple = (x_i[i] & y_i[i]) | (ripple & (x_i[i] ^ y_i[i]));
      end
      co_o = ripple;
   end

endmodule

module serial_add_ctrl #(
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               sub,
   input  logic               cin,
   input  logic               abort,
   input  logic [8*WORDS-1:0] a,
   input  logic [8*WORDS-1:0] b,
   output logic               busy,
   output logic               done,
   output logic [8*WORDS-1:0] sum,
   output logic               cout,
   output logic               ovf
);

   localparam int W     = 8 * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     opa_q, opa_d;
   logic [W-1:0]     opb_q, opb_d;
   logic [W-1:0]     part_q, part_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [7:0]       slice_s;
   logic             slice_co;

   nbitAdder #(.bits(8)) u_slice (
      .x_i  (opa_q[idx_q*8 +: 8]),
      .y_i  (opb_q[idx_q*8 +: 8]),
      .ci_i (carry_q),
      .s_o  (slice_s),
      .co_o (slice_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      part_d  = part_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub | cin;
               idx_d   = '0;
               part_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               part_d[idx_q*8 +: 8] = slice_s;
               carry_d = slice_co;
               idx_d   = idx_q + 1'b1;
               // Final byte: publish the assembled word, including the byte written this cycle.
               if (idx_q == LAST) begin
                  state_d = DONE;
                  idx_d   = '0;
                  sum_d   = part_d;
                  cout_d  = slice_co;
                  ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (part_d[W-1] != opa_q[W-1]);
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed scoreboard bench for serial_add_ctrl
// Expected results are queued at issue and popped when done pulses.

module tb_serial_add_ctrl;

   logic         clk = 1'b0;
   logic         rst_n, start, sub, cin, abort;
   logic [31:0]  a, b, sum;
   logic         busy, done, cout, ovf;

   logic         start2, busy2, done2, cout2, ovf2;
   logic [15:0]  a2, b2, sum2;
   logic         start16, busy16, done16, cout16, ovf16;
   logic [127:0] a16, b16, sum16;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0, fails = 0;
   int   cyc = 0, done_cnt = 0;
   int   tacc, dc, d1, d2, dc0, l2, l16;

   serial_add_ctrl #(.WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .abort(abort),
      .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_add_ctrl #(.WORDS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .cin(cin), .abort(abort),
      .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   serial_add_ctrl #(.WORDS(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .cin(cin), .abort(abort),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic ms, input logic mc);
      exp_t        e;
      logic [31:0] bb;
      logic [32:0] r;
      bb  = ms ? ~mb : mb;
      r   = {1'b0, ma} + {1'b0, bb} + {32'b0, (ms ? 1'b1 : mc)};
      e.s = r[31:0];
      e.c = r[32];
      e.v = (ma[31] == bb[31]) && (r[31] != ma[31]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         done_cnt++;
         chk("busy_done_exclusive", busy, 1'b0);
         chk("sb_nonempty", sbq.size() != 0, 1'b1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_sum", sum, e.s);
            chk("sb_cout", cout, e.c);
            chk("sb_ovf", ovf, e.v);
         end
      end
   end

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                        input logic tc, input bit push, output int t);
      a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
      if (push) sbq.push_back(model(ta, tb_, ts, tc));
      @(posedge clk);
      #1 start = 1'b0;
      t = cyc;
   endtask

   task automatic wait_done(input string tag, output int t);
      t = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk({tag, "_timeout"}, done, 1'b1);
   endtask

   task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                     input logic ts, input logic tc,
                     input logic [31:0] es, input logic ec, input logic ev);
      int ta_c, td_c;
      issue(ta, tb_, ts, tc, 1'b1, ta_c);
      wait_done(tag, td_c);
      chk({tag, "_latency"}, td_c - ta_c, 4);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, ev);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; abort = 1'b0; a = '0; b = '0;
      start2 = 1'b0; a2 = '0; b2 = '0; start16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // byte carry propagation, single done pulse
      dc0 = done_cnt;
      op("carry", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("carry_done_once", done_cnt - dc0, 1);

      op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      op("wrap",    32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
      op("sub_brw", 32'h5,         32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      op("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      op("sub_cin", 32'hA,         32'h3, 1'b1, 1'b1, 32'h7,         1'b1, 1'b0);

      // start held through RUN while operands churn
      dc0 = done_cnt;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, tacc);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 a = $urandom; b = $urandom;
      end
      start = 1'b0;
      wait_done("held", dc);
      chk("held_latency", dc - tacc, 4);
      chk("held_sum", sum, 32'h2345_6789);
      repeat (4) @(negedge clk);
      chk("held_done_once", done_cnt - dc0, 1);
      chk("held_idle", busy, 1'b0);

      // back-to-back: start raised in DONE
      issue(32'h1, 32'h2, 1'b0, 1'b0, 1'b1, tacc);
      wait_done("b2b_first", d1);
      chk("b2b_first_sum", sum, 32'h3);
      issue(32'd100, 32'd1, 1'b1, 1'b0, 1'b1, tacc);
      wait_done("b2b_second", d2);
      chk("b2b_spacing", d2 - d1, 5);
      chk("b2b_second_sum", sum, 32'd99);
      repeat (3) @(negedge clk);

      // abort on the second RUN cycle
      dc0 = done_cnt;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, tacc);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort_idle", busy, 1'b0);
      repeat (8) @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 0);
      chk("abort_sum_kept", sum, 32'd99);
      chk("abort_cout_kept", cout, 1'b1);
      chk("abort_ovf_kept", ovf, 1'b0);

      // asynchronous reset in the middle of RUN
      issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, tacc);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_sum", sum, 32'h0);
      chk("arst_cout", cout, 1'b0);
      chk("arst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op("post_rst", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

      // latency scaling with WORDS=2 and WORDS=16
      sub = 1'b0; cin = 1'b0;
      a2 = 16'h00FF; b2 = 16'h1;
      a16 = {8'h00, {120{1'b1}}}; b16 = 128'h1;
      start2 = 1'b1; start16 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0; start16 = 1'b0;
      tacc = cyc; l2 = -1; l16 = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done2 && l2 < 0) l2 = cyc - tacc;
         if (done16 && l16 < 0) l16 = cyc - tacc;
      end
      chk("w2_latency", l2, 2);
      chk("w16_latency", l16, 16);
      chk("w2_sum", sum2, 16'h0100);
      chk("w2_ovf", ovf2, 1'b0);
      chk("w16_sum", sum16, {8'h01, 120'h0});
      chk("w16_cout", cout16, 1'b0);
      chk("w16_idle", busy16 | busy2, 1'b0);
      chk("sb_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
